// File: rtl/tnn_pkg.sv
// Shared types and default constants for the temporal neural network blocks.
package tnn_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_INPUTS       = 8;
  localparam int DEF_NEURONS      = 8;
  localparam int DEF_WEIGHT_BITS  = 3;
  localparam int DEF_THRESHOLD    = 8;
  localparam int DEF_GAMMA_CYCLES = 16;

  // Width that holds the largest potential a neuron can ever reach:
  // every synapse contributes at most its maximum weight per window.
  function automatic int pot_width(input int inputs, input int weight_bits);
    return $clog2(inputs * ((1 << weight_bits) - 1) + 1);
  endfunction

endpackage

// File: rtl/srm_neuron.sv
// One excitatory neuron: captured weight row, ramp-no-leak contributions,
// accumulating body potential and a stay-low output spike.
module srm_neuron
  import tnn_pkg::*;
#(
  parameter int INPUTS      = DEF_INPUTS,
  parameter int WEIGHT_BITS = DEF_WEIGHT_BITS,
  parameter int THRESHOLD   = DEF_THRESHOLD
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          step,
  input  logic                          finish,
  input  logic [INPUTS*WEIGHT_BITS-1:0] weights_row,
  input  logic [INPUTS-1:0]             seen,
  input  logic [INPUTS*WEIGHT_BITS-1:0] ages,
  output logic                          out_spike
);

  localparam int PW = pot_width(INPUTS, WEIGHT_BITS);

  logic [INPUTS*WEIGHT_BITS-1:0] w_reg;
  logic [INPUTS-1:0]             contrib;
  logic [PW-1:0]                 contrib_cnt;
  logic [PW-1:0]                 potential_reg;
  logic [PW-1:0]                 potential_next;
  logic                          fire;
  logic                          spike_reg;

  // A synapse ramps for w cycles after its input was seen; weight 0 never fires.
  for (genvar gi = 0; gi < INPUTS; gi++) begin : g_syn
    assign contrib[gi] = seen[gi] &&
        (ages[gi*WEIGHT_BITS +: WEIGHT_BITS] < w_reg[gi*WEIGHT_BITS +: WEIGHT_BITS]);
  end

  // Popcount of this cycle's contributions and the resulting potential.
  always_comb begin
    contrib_cnt = '0;
    for (int i = 0; i < INPUTS; i++) begin
      if (contrib[i]) contrib_cnt = contrib_cnt + PW'(1);
    end
    potential_next = potential_reg + contrib_cnt;
    fire           = int'(potential_next) >= THRESHOLD;
  end

  // Weight capture, potential accumulation and spike latch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_reg         <= '0;
      potential_reg <= '0;
      spike_reg     <= 1'b1;
    end else if (start) begin
      w_reg         <= weights_row;
      potential_reg <= '0;
      spike_reg     <= 1'b1;
    end else if (step) begin
      potential_reg <= potential_next;
      if (finish)    spike_reg <= 1'b1;
      else if (fire) spike_reg <= 1'b0;
    end
  end

  assign out_spike = spike_reg;

endmodule

// File: rtl/srm_column.sv
// Column of SRM neurons sharing per-input seen/age tracking over a gamma window.
module srm_column
  import tnn_pkg::*;
#(
  parameter int INPUTS       = DEF_INPUTS,
  parameter int NEURONS      = DEF_NEURONS,
  parameter int WEIGHT_BITS  = DEF_WEIGHT_BITS,
  parameter int THRESHOLD    = DEF_THRESHOLD,
  parameter int GAMMA_CYCLES = DEF_GAMMA_CYCLES
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  gamma_start,
  input  logic [INPUTS-1:0]                     in_spikes,
  input  logic [NEURONS*INPUTS*WEIGHT_BITS-1:0] weights,
  output logic [NEURONS-1:0]                    out_spikes,
  output logic                                  done
);

  localparam int CW = (GAMMA_CYCLES > 1) ? $clog2(GAMMA_CYCLES) : 1;
  localparam logic [CW-1:0]          LAST_CYCLE = CW'(GAMMA_CYCLES - 1);
  localparam logic [WEIGHT_BITS-1:0] AGE_MAX    = '1;

  state_t                        state_reg;
  state_t                        state_next;
  logic                          start;
  logic                          last;
  logic                          running;
  logic [CW-1:0]                 cycle_reg;
  logic                          done_reg;
  logic                          seen_reg [INPUTS];
  logic [WEIGHT_BITS-1:0]        age_reg  [INPUTS];
  logic [INPUTS-1:0]             seen_vec;
  logic [INPUTS*WEIGHT_BITS-1:0] age_vec;

  assign running = (state_reg == RUN);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next state plus the window-open and window-close strobes.
  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    last       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (gamma_start) begin
          state_next = RUN;
          start      = 1'b1;
        end
      end
      RUN: begin
        if (cycle_reg == LAST_CYCLE) begin
          state_next = IDLE;
          last       = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Position within the window, zero in the first RUN cycle.
  always_ff @(posedge clk) begin
    if (!rst_n || start) cycle_reg <= '0;
    else if (running)    cycle_reg <= cycle_reg + CW'(1);
  end

  // One-cycle completion pulse after the final RUN cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) done_reg <= 1'b0;
    else        done_reg <= last;
  end

  // Per-input first-spike detection and saturating age, shared by all neurons.
  for (genvar gi = 0; gi < INPUTS; gi++) begin : g_input
    always_ff @(posedge clk) begin
      if (!rst_n || start) begin
        seen_reg[gi] <= 1'b0;
        age_reg[gi]  <= '0;
      end else if (running) begin
        if (!seen_reg[gi] && !in_spikes[gi]) begin
          seen_reg[gi] <= 1'b1;
          age_reg[gi]  <= '0;
        end else if (seen_reg[gi] && age_reg[gi] != AGE_MAX) begin
          age_reg[gi]  <= age_reg[gi] + WEIGHT_BITS'(1);
        end
      end
    end
    assign seen_vec[gi] = seen_reg[gi];
    assign age_vec[gi*WEIGHT_BITS +: WEIGHT_BITS] = age_reg[gi];
  end

  for (genvar gi = 0; gi < NEURONS; gi++) begin : g_neuron
    srm_neuron #(
      .INPUTS      (INPUTS),
      .WEIGHT_BITS (WEIGHT_BITS),
      .THRESHOLD   (THRESHOLD)
    ) u_neuron (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .step        (running),
      .finish      (last),
      .weights_row (weights[gi*INPUTS*WEIGHT_BITS +: INPUTS*WEIGHT_BITS]),
      .seen        (seen_vec),
      .ages        (age_vec),
      .out_spike   (out_spikes[gi])
    );
  end

  assign done = done_reg;

endmodule
